// File: rtl/wb_host_master.sv
// Wishbone classic single-beat initiator: turns requester commands into cyc/stb cycles
// and returns read data and status on a valid/ready response channel with timeout abort.
module wb_host_master #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_adr,
    input  logic [DW-1:0]     cmd_dat,
    input  logic [DW/8-1:0]   cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_dat,
    output logic              rsp_err,
    output logic              rsp_tout,
    output logic              busy,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [AW-1:0]     wbm_adr_o,
    output logic [DW-1:0]     wbm_dat_o,
    output logic [DW/8-1:0]   wbm_sel_o,
    input  logic [DW-1:0]     wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i
);

    localparam int unsigned SELW      = DW / 8;
    localparam int unsigned CNTW      = 16;
    localparam bit          TOUT_EN   = (TIMEOUT != 0);
    localparam logic [CNTW-1:0] TOUT_LAST = (TIMEOUT == 0) ? CNTW'(0) : CNTW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_tout_q, rsp_tout_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_tout_d  = rsp_tout_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = ST_BUS;
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    we_d        = cmd_we;
                    adr_d       = cmd_adr;
                    sel_d       = cmd_sel;
                    dat_d       = cmd_we ? cmd_dat : '0;
                end
            end
            ST_BUS: begin
                if (wbm_err_i || wbm_ack_i || (TOUT_EN && (cnt_q == TOUT_LAST))) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_tout_d  = 1'b0;
                    rsp_dat_d   = '0;
                    // err outranks ack; timeout only when the slave is silent
                    if (!wbm_err_i && wbm_ack_i) begin
                        rsp_err_d = 1'b0;
                        rsp_dat_d = we_q ? '0 : wbm_dat_i;
                    end else if (!wbm_err_i) begin
                        rsp_tout_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b0;
                    rsp_tout_d  = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b0;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tout_q  <= rsp_tout_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_tout  = rsp_tout_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Randomized bench for wb_host_master: a slave responder plus a transaction-level
// reference model predicting stb duration and response fields.
module tb_wb_host_master;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SELW = 4;
    localparam int unsigned TOUT = 8;

    logic            wb_clk_i;
    logic            wb_rst_i;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic [AW-1:0]   cmd_adr;
    logic [DW-1:0]   cmd_dat;
    logic [SELW-1:0] cmd_sel;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_dat;
    logic            rsp_err;
    logic            rsp_tout;
    logic            busy;
    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic            wbm_we_o;
    logic [AW-1:0]   wbm_adr_o;
    logic [DW-1:0]   wbm_dat_o;
    logic [SELW-1:0] wbm_sel_o;
    logic [DW-1:0]   wbm_dat_i;
    logic            wbm_ack_i;
    logic            wbm_err_i;

    int errors = 0;
    int checks = 0;

    wb_host_master #(.AW(AW), .DW(DW), .TIMEOUT(TOUT)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .rsp_tout (rsp_tout),
        .busy     (busy),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // mode: 0 ack, 1 err, 2 err+ack, 3 silent slave; wt = wait cycles before responding
    task automatic model(input logic we, input int mode, input int wt, input logic [31:0] rdata,
                         output int ncyc, output logic err, output logic tout,
                         output logic [31:0] dat);
        bit responds;
        responds = (mode != 3) && (wt < int'(TOUT));
        ncyc     = responds ? wt + 1 : int'(TOUT);
        tout     = !responds;
        err      = tout || (mode == 1) || (mode == 2);
        dat      = (!err && !we) ? rdata : 32'h0;
    endtask

    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int mode, input int wt,
                          input logic [31:0] rdata, input int rd);
        int          n_exp;
        logic        e_err;
        logic        e_tout;
        logic [31:0] e_dat;
        int          w;
        int          n;
        model(we, mode, wt, rdata, n_exp, e_err, e_tout, e_dat);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        rsp_ready = (rd == 0);
        w = 0;
        @(negedge wb_clk_i);
        while (!cmd_ready && w < 20) begin
            w++;
            @(negedge wb_clk_i);
        end
        check("cmd_wait", 64'(w), 64'd0);
        @(posedge wb_clk_i);
        #1;
        // garbage on the command port while busy must be ignored
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_we    = 1'($urandom);
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = 4'($urandom);
        check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        check("busy", 64'(busy), 64'd1);
        n = 0;
        while (wbm_stb_o && n < 40) begin
            check("cyc", 64'(wbm_cyc_o), 64'd1);
            check("adr", 64'(wbm_adr_o), 64'(adr));
            check("dat_o", 64'(wbm_dat_o), we ? 64'(dat) : 64'd0);
            check("sel", 64'(wbm_sel_o), 64'(sel));
            check("we", 64'(wbm_we_o), 64'(we));
            wbm_dat_i = $urandom;
            if (n == wt && mode != 3) begin
                wbm_ack_i = (mode != 1);
                wbm_err_i = (mode != 0);
                wbm_dat_i = rdata;
            end
            @(posedge wb_clk_i);
            #1;
            n++;
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
        end
        check("stb_cycles", 64'(n), 64'(n_exp));
        check("cyc_low", 64'(wbm_cyc_o), 64'd0);
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_err", 64'(rsp_err), 64'(e_err));
        check("rsp_tout", 64'(rsp_tout), 64'(e_tout));
        check("rsp_dat", 64'(rsp_dat), 64'(e_dat));
        for (int i = 0; i < rd; i++) begin
            wbm_ack_i = 1'($urandom);
            wbm_err_i = 1'($urandom);
            wbm_dat_i = $urandom;
            @(posedge wb_clk_i);
            #1;
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_dat", 64'(rsp_dat), 64'(e_dat));
            check("hold_err", 64'(rsp_err), 64'(e_err));
            check("hold_tout", 64'(rsp_tout), 64'(e_tout));
            check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        rsp_ready = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check("rsp_done", 64'(rsp_valid), 64'd0);
        check("cmd_ready_after", 64'(cmd_ready), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_cyc", 64'(wbm_cyc_o), 64'd0);
        check("rst_stb", 64'(wbm_stb_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_adr", 64'(wbm_adr_o), 64'd0);
        wb_rst_i = 1'b0;
        #1;
        check("rel_cmd_ready0", 64'(cmd_ready), 64'd0);
        @(posedge wb_clk_i);
        #1;
        check("rel_cmd_ready1", 64'(cmd_ready), 64'd1);

        // Stray slave responses while idle are ignored
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        check("idle_stray_valid", 64'(rsp_valid), 64'd0);
        check("idle_stray_busy", 64'(busy), 64'd0);

        do_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 0, 32'h0, 0);
        do_txn(1'b0, 32'h3000_0010, 32'h1111_2222, 4'h3, 0, 3, 32'hCAFE_F00D, 0);
        do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 2, 1, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 3, 0, 32'h0, 0);
        do_txn(1'b0, 32'h3000_0034, 32'h0, 4'hF, 0, 2, 32'h1234_5678, 0);
        do_txn(1'b0, 32'h3000_0040, 32'h0, 4'h1, 0, 1, 32'h0BAD_CAFE, 5);
        do_txn(1'b1, 32'h3000_0044, 32'h5555_AAAA, 4'hC, 0, 7, 32'h0, 0);

        // Asynchronous reset in the middle of a bus cycle
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0050;
        cmd_sel   = 4'hF;
        @(posedge wb_clk_i);
        #1;
        cmd_valid = 1'b0;
        check("pre_rst_stb", 64'(wbm_stb_o), 64'd1);
        @(posedge wb_clk_i);
        #3;
        wb_rst_i = 1'b1;
        #1;
        check("mid_rst_cyc", 64'(wbm_cyc_o), 64'd0);
        check("mid_rst_stb", 64'(wbm_stb_o), 64'd0);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_ready", 64'(cmd_ready), 64'd0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFFFF_0000;
        @(posedge wb_clk_i);
        #1;
        wbm_ack_i = 1'b0;
        wb_rst_i  = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge wb_clk_i);
            #1;
            check("post_rst_valid", 64'(rsp_valid), 64'd0);
            check("post_rst_ready", 64'(cmd_ready), 64'd1);
            check("post_rst_cyc", 64'(wbm_cyc_o), 64'd0);
        end
        do_txn(1'b0, 32'h3000_0060, 32'h0, 4'hF, 0, 0, 32'h7777_8888, 1);

        for (int t = 0; t < 40; t++) begin
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                   $urandom, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
